dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the memory-access (M) stage of the pipelined RV32I core.
- Services load and store requests from the datapath, with byte, halfword and word sizes and sign or zero extension.
- Inserts a fixed number of wait states and raises a stall request to the hazard unit while a request is in flight.
- Replaces the single-cycle data memory in the M stage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in storage; must be a power of two.
- LATENCY, 2, wait cycles from acceptance to completion; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_M  in  1  M-stage instruction is a load or store.
- req_we_M  in  1  1 = store, 0 = load.
- req_addr_M  in  32  byte address (ALUResultM).
- req_wdata_M  in  32  store data (WriteDataM), taken from the low lanes.
- req_size_M  in  2  00 byte, 01 half, 10 word, 11 reserved (funct3[1:0]).
- req_unsigned_M  in  1  load zero-extends when 1 (funct3[2]).
- stall_mem  out  1  hold F/D/E/M; flush nothing.
- rdata_M  out  32  extended load data (ReadDataM).
- rdata_valid_M  out  1  one-cycle pulse: rdata_M is updated this cycle.
- misalign_err_M  out  1  one-cycle pulse: the completed request was misaligned or reserved.

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, counter 0, stall_mem 0, rdata_M 0, rdata_valid_M 0, misalign_err_M 0, captured request cleared. Storage array is not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req_valid_M is high, capture addr/wdata/we/size/unsigned, load counter = LATENCY-1, go to WAIT.
  - stall_mem = req_valid_M, combinational, in the acceptance cycle.
- WAIT:
  - stall_mem = 1.
  - Counter decrements each cycle; at counter = 0, go to DONE.
  - On that same edge, the captured store is committed, or load data is registered into rdata_M.
- DONE:
  - Lasts exactly one cycle. stall_mem = 0, so the pipeline advances the M instruction at the end of this cycle.
  - rdata_valid_M = 1 for loads; misalign_err_M = 1 if the request was flagged.
  - Next state is IDLE; req_valid_M is ignored in DONE so the same instruction is never accepted twice.
- Latency: request present in cycle T gives completion pulse in cycle T+LATENCY and the next acceptance no earlier than T+LATENCY+1. Back-to-back memory instructions therefore cost LATENCY+1 cycles each.
- Inputs after acceptance: changes on req_* during WAIT are ignored; the captured copy is used.
- rdata_M holds its last load value until the next load completes. Stores and misaligned requests do not change rdata_M, except that a misaligned load sets it to 0.
- Indexing: word index = req_addr_M[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Store lanes:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all four lanes. Untouched lanes are preserved.
- Load extract: lane selection as for stores; sign-extend from bit 7/15 unless req_unsigned_M, in which case zero-extend.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size 11. Such a request produces no write and the misalign_err_M pulse in DONE.
- Reset mid-operation: asserted in WAIT, a pending store is discarded (no write) and no pulse is produced.

Decomposition:
- Shared package (core_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, dmem FSM state encoding, LATENCY legal-range constant.
- Sub-module dmem_lane_align (combinational):
  - byte-enable and shifted write data from addr/size;
  - extracted, extended load data;
  - misalign flag.

Test Plan:
- Reset then SW 0xDEADBEEF @0x10, LW @0x10, LATENCY=2 -> stall_mem high cycles T and T+1; rdata_valid_M pulse at T+2 with rdata_M=0xDEADBEEF.
- SB 0x80 @0x11, then LB @0x11 and LBU @0x11 -> rdata_M=0xFFFFFF80 then 0x00000080; LW @0x10 = 0xDEAD80EF.
- SH 0x1234 @0x22, LH @0x22 -> 0x00001234; LW @0x20 has upper half 0x1234 and lower half unchanged.
- LW @0x13 and SH @0x21 -> misalign_err_M pulse in DONE, no memory change, rdata_M=0 after the LW.
- SW 0xCAFEF00D @(4*DEPTH_WORDS+0x4), LW @0x4 -> 0xCAFEF00D (wrap-around).
- SW 0x11111111 @0x8 accepted, reset pulsed during WAIT, then LW @0x8 -> old value unchanged, and no rdata_valid_M/misalign_err_M pulse appears for the aborted store.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core's memory-stage logic.
// Contents:
//   SZ_*        access size encodings (funct3[1:0])
//   DMEM_*      dmem_responder FSM state encoding
//   DMEM_LAT_*  legal range of the dmem_responder LATENCY parameter
//   is_misaligned()  flags a misaligned access or the reserved size

package core_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] DMEM_IDLE = 2'b00;
    localparam logic [1:0] DMEM_WAIT = 2'b01;
    localparam logic [1:0] DMEM_DONE = 2'b10;

    localparam int unsigned DMEM_LAT_MIN = 1;
    localparam int unsigned DMEM_LAT_MAX = 15;

    // The reserved size is treated like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        unique case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment for data-memory accesses.
// Ports:
//   addr_lo_i    byte offset within the word (addr[1:0])
//   size_i       access size (SZ_*)
//   unsigned_i   zero-extend loads when 1
//   wdata_i      store data, taken from the low lanes
//   rword_i      full 32-bit word read from storage
//   be_o         byte enables for a store (all zero when misaligned)
//   wdata_o      store data replicated so each enabled lane sees its byte
//   rdata_o      extracted and extended load data (zero when misaligned)
//   misalign_o   access is misaligned or uses the reserved size

module dmem_lane_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        misalign_o = is_misaligned(size_i, addr_lo_i);

        // Replicating the low byte/half across the word means the byte enables
        // alone pick the destination lane; no barrel shift is needed.
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
        if (misalign_o) begin
            be_o = 4'b0000;
        end
    end

    always_comb begin
        unique case (addr_lo_i)
            2'b00:   byte_sel = rword_i[7:0];
            2'b01:   byte_sel = rword_i[15:8];
            2'b10:   byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        rdata_o = 32'h0;
        unique case (size_i)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
        if (misalign_o) begin
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage of the RV32I pipeline.
// A request is accepted in IDLE, held for LATENCY cycles (stall_mem high),
// committed on the edge into DONE, and reported during the single DONE cycle.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two
//   LATENCY      cycles from acceptance to the completion pulse, 1..15
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   req_*_M          load/store request from the M stage
//   stall_mem        hold F/D/E/M while a request is in flight
//   rdata_M          extended load data, held until the next load completes
//   rdata_valid_M    one-cycle pulse when a load completes
//   misalign_err_M   one-cycle pulse when a misaligned/reserved request completes

module dmem_responder
    import core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_M,
    input  logic        req_we_M,
    input  logic [31:0] req_addr_M,
    input  logic [31:0] req_wdata_M,
    input  logic [1:0]  req_size_M,
    input  logic        req_unsigned_M,
    output logic        stall_mem,
    output logic [31:0] rdata_M,
    output logic        rdata_valid_M,
    output logic        misalign_err_M
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   rdata_q;
    logic          rvalid_q;
    logic          mis_q;

    logic          accept;
    logic          commit;
    logic          cur_we;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic          cur_uns;
    logic [AW-1:0] cur_idx;

    logic [3:0]    la_be;
    logic [31:0]   la_wdata;
    logic [31:0]   la_rdata;
    logic          la_mis;

    // Address bits above the storage range wrap and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_M[31:AW+2];

    assign accept = (state_q == DMEM_IDLE) && req_valid_M;

    // With LATENCY == 1 the commit happens on the acceptance edge itself, so
    // the request must come straight from the ports rather than the capture.
    always_comb begin
        if (state_q == DMEM_IDLE) begin
            cur_we    = req_we_M;
            cur_addr  = req_addr_M[AW+1:0];
            cur_wdata = req_wdata_M;
            cur_size  = req_size_M;
            cur_uns   = req_unsigned_M;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
        end
    end

    assign cur_idx = cur_addr[AW+1:2];

    dmem_lane_align u_lane_align (
        .addr_lo_i  (cur_addr[1:0]),
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .wdata_i    (cur_wdata),
        .rword_i    (mem[cur_idx]),
        .be_o       (la_be),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata),
        .misalign_o (la_mis)
    );

    // cnt holds the cycles still to elapse before DONE; the request commits
    // on the edge where it would reach zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        stall_mem = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                stall_mem = req_valid_M;
                if (req_valid_M) begin
                    cnt_d = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        state_d = DMEM_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                stall_mem = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = DMEM_DONE;
                    commit  = 1'b1;
                end
            end
            DMEM_DONE: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we_M;
                addr_q  <= req_addr_M[AW+1:0];
                wdata_q <= req_wdata_M;
                size_q  <= req_size_M;
                uns_q   <= req_unsigned_M;
            end
            rvalid_q <= commit && !cur_we;
            mis_q    <= commit && la_mis;
            // la_rdata is already zero for a misaligned load.
            if (commit && !cur_we) begin
                rdata_q <= la_rdata;
            end
        end
    end

    // Storage is not reset; la_be is all-zero for misaligned stores.
    always_ff @(posedge clk) begin
        if (commit && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (la_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= la_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_M        = rdata_q;
    assign rdata_valid_M  = rvalid_q;
    assign misalign_err_M = mis_q;

endmodule
